exu_div: RTL and testbench



---
 rtl/exu_div.sv | 147 ++++++++++++++
 tb/tb_exu_div.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div.sv
// Iterative radix-2 restoring unsigned divide/remainder unit; divide by zero gives q=0, r=dividend.
// Optional macro DIV_EARLY_OUT_EN: shortcuts for divisor 0, divisor > dividend and divisor 1.
module exu_div #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           pipe_flush,
  input  logic                           div_valid,
  input  logic                           div_remu,
  input  logic [XLEN-1:0]                div_rs1_data,
  input  logic [XLEN-1:0]                div_rs2_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
  output logic                           exu_div_busy,
  output logic [XLEN-1:0]                div_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
  output logic                           div_wb_rd_wr_en
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state, next_state;
  logic [XLEN-1:0]                quo, rem, dvsr;
  logic [CNT_W-1:0]               cnt;
  logic                           remu_q, dz_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_q;

  logic                           accept;
  logic                           early;
  logic [XLEN-1:0]                early_res;
  logic [XLEN:0]                  shifted, trial;
  logic                           qbit;
  logic [XLEN-1:0]                quo_nxt, rem_nxt;

  logic                           busy_d, wr_en_d;
  logic [XLEN-1:0]                wb_data_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_addr_d;

  function automatic logic [XLEN-1:0] pick_result(input logic r_sel, input logic dz,
                                                  input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r);
    if (r_sel)   return r;
    else if (dz) return '0;
    else         return q;
  endfunction

`ifdef DIV_EARLY_OUT_EN
  function automatic logic [XLEN-1:0] shortcut_result(input logic r_sel,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
    if (b == '0 || b > a) return r_sel ? a : '0;
    else                  return r_sel ? '0 : a;
  endfunction

  assign early     = (div_rs2_data == '0) || (div_rs2_data > div_rs1_data) ||
                     (div_rs2_data == XLEN'(1));
  assign early_res = shortcut_result(div_remu, div_rs1_data, div_rs2_data);
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  assign accept = (state == IDLE) && div_valid && !pipe_flush;

  // Full-width trial keeps divisors with the MSB set exact; sign bit picks restore vs subtract.
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr};
  assign qbit    = !trial[XLEN];
  assign rem_nxt = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], qbit};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = early ? DONE : RUN;
      RUN:     if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (pipe_flush) next_state = IDLE;
  end

  always_comb begin
    busy_d    = (next_state != IDLE);
    wr_en_d   = (next_state == DONE);
    wb_data_d = div_wb_data;
    wb_addr_d = div_wb_rd_addr;
    if (next_state == DONE) begin
      if (state == IDLE) begin
        wb_data_d = early_res;
        wb_addr_d = div_rd_addr;
      end else begin
        wb_data_d = pick_result(remu_q, dz_q, quo_nxt, rem_nxt);
        wb_addr_d = rd_q;
      end
    end
  end

  // Stage boundary: operand latch and iteration registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      remu_q <= 1'b0;
      dz_q   <= 1'b0;
      rd_q   <= '0;
    end else if (accept) begin
      quo    <= div_rs1_data;
      rem    <= '0;
      dvsr   <= div_rs2_data;
      cnt    <= CNT_W'(XLEN-1);
      remu_q <= div_remu;
      dz_q   <= (div_rs2_data == '0);
      rd_q   <= div_rd_addr;
    end else if (state == RUN) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  // Stage boundary: registered writeback and busy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exu_div_busy    <= 1'b0;
      div_wb_rd_wr_en <= 1'b0;
      div_wb_data     <= '0;
      div_wb_rd_addr  <= '0;
    end else begin
      exu_div_busy    <= busy_d;
      div_wb_rd_wr_en <= wr_en_d;
      div_wb_data     <= wb_data_d;
      div_wb_rd_addr  <= wb_addr_d;
    end
  end

endmodule

// File: tb/tb_exu_div.sv
// Scoreboard bench for exu_div: expected writebacks queued at issue, popped on each wr_en pulse.
module tb_exu_div;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            pipe_flush = 1'b0;
  logic            div_valid = 1'b0;
  logic            div_remu = 1'b0;
  logic [XLEN-1:0] div_rs1_data = '0;
  logic [XLEN-1:0] div_rs2_data = '0;
  logic [AW-1:0]   div_rd_addr = '0;
  logic            exu_div_busy;
  logic [XLEN-1:0] div_wb_data;
  logic [AW-1:0]   div_wb_rd_addr;
  logic            div_wb_rd_wr_en;

  int errors = 0;
  int checks = 0;
  int wb_cnt = 0;
  logic [XLEN+AW-1:0] sb_q[$];

  exu_div #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .pipe_flush(pipe_flush), .div_valid(div_valid),
    .div_remu(div_remu), .div_rs1_data(div_rs1_data), .div_rs2_data(div_rs2_data),
    .div_rd_addr(div_rd_addr), .exu_div_busy(exu_div_busy), .div_wb_data(div_wb_data),
    .div_wb_rd_addr(div_wb_rd_addr), .div_wb_rd_wr_en(div_wb_rd_wr_en)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every writeback pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && div_wb_rd_wr_en) begin
      logic [XLEN+AW-1:0] exp;
      wb_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got data=%h addr=%0d, expected no writeback",
                 div_wb_data, div_wb_rd_addr);
      end else begin
        exp = sb_q.pop_front();
        if ({div_wb_data, div_wb_rd_addr} !== exp) begin
          errors++;
          $display("FAIL wb_data: got data=%h addr=%0d, expected data=%h addr=%0d",
                   div_wb_data, div_wb_rd_addr, exp[XLEN+AW-1:AW], exp[AW-1:0]);
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic r);
    if (b == 0) return r ? a : '0;
    return r ? (a % b) : (a / b);
  endfunction

  function automatic int latency(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || b > a || b == 1) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic drive_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic r, input logic [AW-1:0] rd);
    div_valid = 1'b1; div_rs1_data = a; div_rs2_data = b; div_remu = r; div_rd_addr = rd;
  endtask

  // Issue one op, then check busy/wr_en every cycle through one cycle past writeback.
  task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic r, input logic [AW-1:0] rd, input string name);
    int lat;
    lat = latency(a, b);
    @(negedge clk);
    drive_op(a, b, r, rd);
    sb_q.push_back({model(a, b, r), rd});
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      checks++;
      if (exu_div_busy !== (c <= lat)) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b, expected %b", name, c, exu_div_busy, c <= lat);
      end
      checks++;
      if (div_wb_rd_wr_en !== (c == lat)) begin
        errors++;
        $display("FAIL %s wr_en cyc %0d: got %b, expected %b", name, c, div_wb_rd_wr_en, c == lat);
      end
      @(negedge clk);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s sb_drain: got %0d pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({exu_div_busy, div_wb_rd_wr_en, div_wb_data, div_wb_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got busy=%b wr=%b data=%h addr=%0d, expected all 0",
               exu_div_busy, div_wb_rd_wr_en, div_wb_data, div_wb_rd_addr);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide();
    run_op(32'd100, 32'd7, 1'b0, 5'd5, "div100_7");
    run_op(32'd100, 32'd7, 1'b1, 5'd6, "rem100_7");
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 5'd7, "divFFFF_10");
    run_op(32'hFFFF_FFFF, 32'h10, 1'b1, 5'd8, "remFFFF_10");
    run_op(32'hDEAD_BEEF, 32'h8000_0001, 1'b1, 5'd9, "rem_bigdiv");
    run_op(32'd12345, 32'd1, 1'b0, 5'd10, "div_by_one");
  endtask

  task automatic test_div_zero();
    run_op(32'h1234, 32'd0, 1'b0, 5'd11, "dz_quo");
    run_op(32'h1234, 32'd0, 1'b1, 5'd12, "dz_rem");
    run_op(32'd5, 32'd9, 1'b0, 5'd13, "small_over_big");
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_op(32'd100, 32'd7, 1'b0, 5'd14);
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    pipe_flush = 1'b1;
    @(negedge clk);
    pipe_flush = 1'b0;
    checks++;
    if ({exu_div_busy, div_wb_rd_wr_en} !== 2'b00) begin
      errors++;
      $display("FAIL flush_run: got busy=%b wr=%b, expected 0 0", exu_div_busy, div_wb_rd_wr_en);
    end
    run_op(32'd1000, 32'd3, 1'b0, 5'd15, "after_flush");
    @(negedge clk);
    drive_op(32'd50, 32'd5, 1'b0, 5'd16);
    pipe_flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    pipe_flush = 1'b0;
    checks++;
    if (exu_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: got busy=%b, expected 0", exu_div_busy);
    end
    repeat (XLEN + 4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_op(32'hFFFF_FFFF, 32'h10, 1'b0, 5'd17);
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({exu_div_busy, div_wb_rd_wr_en} !== 2'b00) begin
      errors++;
      $display("FAIL async_rst: got busy=%b wr=%b, expected 0 0", exu_div_busy, div_wb_rd_wr_en);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (XLEN + 6) @(negedge clk);
    checks++;
    if (exu_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_idle: got busy=%b, expected 0", exu_div_busy);
    end
    run_op(32'd81, 32'd9, 1'b0, 5'd18, "after_reset");
  endtask

  task automatic test_back_to_back();
    int start_wb;
    int c;
    start_wb = wb_cnt;
    @(negedge clk);
    drive_op(32'd1000, 32'd3, 1'b1, 5'd19);
    sb_q.push_back({model(32'd1000, 32'd3, 1'b1), 5'd19});
    sb_q.push_back({model(32'd77, 32'd5, 1'b0), 5'd20});
    @(posedge clk);
    @(negedge clk);
    drive_op(32'd77, 32'd5, 1'b0, 5'd20);
    c = 1;
    while (exu_div_busy === 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != XLEN + 2) begin
      errors++;
      $display("FAIL b2b_busy_fall: got cycle %0d, expected %0d", c, XLEN + 2);
    end
    @(negedge clk);
    div_valid = 1'b0;
    checks++;
    if (exu_div_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: got busy=%b, expected 1", exu_div_busy);
    end
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (wb_cnt - start_wb != 2) begin
      errors++;
      $display("FAIL b2b_wb_count: got %0d, expected 2", wb_cnt - start_wb);
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
